ray_tri_sched: RTL
==================

RAY_TRI_SCHED -- requirements
Module: ray_tri_sched

Interface
REQ-001 SHALL have parameter IDX_W, default 16: triangle index and count width.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 8: maximum triangles issued but not yet returned by the intersection pipeline.
REQ-003 SHALL have parameter signed T_INIT, default 32'sh7fffffff: closest-t value before any hit.
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_rstn  input  1  reset, synchronous, active-low.
REQ-006 i_start  input  1  begin one sweep; honoured only in IDLE.
REQ-007 i_num_tris  input  IDX_W  triangle count for the sweep; sampled on accepted i_start.
REQ-008 o_busy  output  1  high in every state except IDLE.
REQ-009 o_idx_valid  output  1  triangle index offered to the fetch unit.
REQ-010 o_idx  output  IDX_W  triangle index offered.
REQ-011 i_idx_ready  input  1  fetch unit accepts o_idx; a transfer occurs when o_idx_valid and i_idx_ready are both high.
REQ-012 i_isect_valid  input  1  intersection pipeline result valid; results arrive in issue order.
REQ-013 i_isect_result  input  1  hit flag for the returning triangle.
REQ-014 i_isect_t  input  32 signed  16.16 fixed-point distance for the returning triangle.
REQ-015 o_done  output  1  one-cycle pulse at sweep end.
REQ-016 o_hit  output  1  at least one hit in the sweep.
REQ-017 o_t  output  32 signed  closest hit distance.
REQ-018 o_hit_idx  output  IDX_W  index of the closest hit.
REQ-019 o_err  output  1  sticky protocol error flag.

Function
REQ-020 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-021 IDLE->ISSUE on i_start with i_num_tris!=0; IDLE->DONE on i_start with i_num_tris==0; otherwise remain in IDLE.
REQ-022 On an accepted i_start SHALL clear the issue counter, return counter, o_hit and o_hit_idx, and SHALL load o_t with T_INIT.
REQ-023 In ISSUE, o_idx_valid SHALL be high iff inflight<MAX_INFLIGHT; o_idx SHALL equal the issue counter (0,1,2,... in order).
REQ-024 o_idx SHALL stay stable while o_idx_valid is high and i_idx_ready is low.
REQ-025 On each transfer the issue counter SHALL increment; after transfer of index i_num_tris-1 SHALL go to DRAIN next cycle.
REQ-026 Inflight counter: +1 on transfer, -1 on i_isect_valid, unchanged when both occur in the same cycle; counter width SHALL hold 0..MAX_INFLIGHT.
REQ-027 Each i_isect_valid with inflight>0 SHALL consume the return counter value as that triangle's index, then increment the return counter.
REQ-028 Closest-hit update: if i_isect_result and i_isect_t < o_t (signed, strict), SHALL load o_t<=i_isect_t, o_hit_idx<=returned index, o_hit<=1; on equal t the earlier index SHALL be kept.
REQ-029 Results SHALL be processed in ISSUE and DRAIN; DRAIN->DONE in the cycle after the return counter reaches the latched count.
REQ-030 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE; i_start in DONE SHALL be ignored.
REQ-031 o_hit, o_t and o_hit_idx SHALL hold their values from DONE until the next accepted i_start.
REQ-032 i_isect_valid while inflight==0, or in IDLE or DONE, SHALL be ignored for the closest-hit update and SHALL set o_err=1.
REQ-033 o_err SHALL clear only on reset or on an accepted i_start.
REQ-034 i_start while o_busy is high SHALL be ignored with no effect on the sweep.
REQ-035 i_num_tris of 2^IDX_W-1 SHALL complete without counter wrap.

Reset
REQ-036 While i_rstn==0 at a clock edge, SHALL enter IDLE with all counters 0 and o_busy=0, o_idx_valid=0, o_idx=0, o_done=0, o_hit=0, o_t=T_INIT, o_hit_idx=0, o_err=0.
REQ-037 Reset asserted mid-sweep SHALL abandon the sweep; results arriving afterward SHALL only set o_err.

Verification
REQ-038 i_num_tris=0, i_start pulse -> o_done pulse 2 cycles later, o_hit=0, o_t=32'h7fffffff, no o_idx_valid.
REQ-039 i_num_tris=4, ready always 1, 3-cycle pipeline model, hits t=5.0,2.0,2.0,9.0 -> o_idx 0..3 on consecutive cycles; o_hit=1, o_t=32'h00020000, o_hit_idx=1.
REQ-040 i_num_tris=20, MAX_INFLIGHT=8, results withheld -> exactly 8 transfers, then o_idx_valid=0 until the first result returns.
REQ-041 Random i_idx_ready stalls -> o_idx stable while stalled; every index 0..N-1 issued exactly once; closest hit matches the reference model.
REQ-042 i_isect_valid pulse in IDLE -> o_err=1, o_t unchanged; next i_start -> o_err=0.
REQ-043 Reset during DRAIN with 3 in flight -> IDLE next cycle with reset values; the 3 late results set o_err=1 only.

Source files
------------

// File: rtl/ray_tri_sched.sv
// ray_tri_sched
// -----------------------------------------------------------------------------
// Schedules one ray-vs-triangle sweep: issues triangle indices 0..N-1 to a
// fetch unit under a valid/ready handshake, caps the number of triangles
// outstanding in the intersection pipeline, and folds the in-order results
// into a closest-hit record (distance + triangle index).
//
// Ports
//   i_clk, i_rstn      clock, synchronous active-low reset
//   i_start            begin a sweep (honoured only in IDLE)
//   i_num_tris         triangle count, sampled on an accepted i_start
//   o_busy             high whenever the scheduler is not IDLE
//   o_idx_valid/o_idx  triangle index offered to the fetch unit
//   i_idx_ready        fetch unit accepts o_idx
//   i_isect_valid      intersection result valid (results return in issue order)
//   i_isect_result     hit flag of the returning triangle
//   i_isect_t          signed 16.16 hit distance of the returning triangle
//   o_done             one-cycle pulse at sweep end
//   o_hit/o_t/o_hit_idx closest-hit record, held until the next sweep starts
//   o_err              sticky flag for results arriving when none are expected
// -----------------------------------------------------------------------------
module ray_tri_sched #(
    parameter int                 IDX_W        = 16,
    parameter int                 MAX_INFLIGHT = 8,
    parameter logic signed [31:0] T_INIT       = 32'sh7fffffff
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_start,
    input  logic [IDX_W-1:0]        i_num_tris,
    output logic                    o_busy,
    output logic                    o_idx_valid,
    output logic [IDX_W-1:0]        o_idx,
    input  logic                    i_idx_ready,
    input  logic                    i_isect_valid,
    input  logic                    i_isect_result,
    input  logic signed [31:0]      i_isect_t,
    output logic                    o_done,
    output logic                    o_hit,
    output logic signed [31:0]      o_t,
    output logic [IDX_W-1:0]        o_hit_idx,
    output logic                    o_err
);

    // Wide enough to represent every value 0..MAX_INFLIGHT inclusive.
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] num_lat;    // triangle count latched at start
    logic [IDX_W-1:0] issue_cnt;  // next index to offer
    logic [IDX_W-1:0] ret_cnt;    // index of the next result to come back
    logic [INF_W-1:0] inflight;   // issued but not yet returned

    logic xfer;
    logic active;
    logic consume;
    logic stray;
    logic closer;

    // Outputs below are plain decodes of registered state; nothing here
    // depends combinationally on an input except the handshake qualifiers.
    always_comb begin
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        o_idx       = issue_cnt;
        o_idx_valid = (state == ISSUE) && (inflight < INF_W'(MAX_INFLIGHT));
        xfer        = o_idx_valid && i_idx_ready;
        active      = (state == ISSUE) || (state == DRAIN);
        // A result is only meaningful if something is actually outstanding.
        consume     = i_isect_valid && active && (inflight != '0);
        stray       = i_isect_valid && !consume;
        // Strict signed compare: on equal distance the earlier index wins.
        closer      = consume && i_isect_result && (i_isect_t < o_t);
    end

    // NOTE: every register here is assigned with <= so that all updates in a
    // cycle see the same pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= IDLE;
            num_lat   <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            inflight  <= '0;
            o_hit     <= 1'b0;
            o_t       <= T_INIT;
            o_hit_idx <= '0;
            o_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        num_lat   <= i_num_tris;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        o_hit     <= 1'b0;
                        o_t       <= T_INIT;
                        o_hit_idx <= '0;
                        o_err     <= 1'b0;
                        state     <= (i_num_tris == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        issue_cnt <= issue_cnt + IDX_W'(1);
                        if (issue_cnt == num_lat - IDX_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (ret_cnt == num_lat) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (consume) begin
                ret_cnt <= ret_cnt + IDX_W'(1);
                if (closer) begin
                    o_t       <= i_isect_t;
                    o_hit_idx <= ret_cnt;
                    o_hit     <= 1'b1;
                end
            end

            // Simultaneous issue and return leave the count unchanged.
            case ({xfer, consume})
                2'b10:   inflight <= inflight + INF_W'(1);
                2'b01:   inflight <= inflight - INF_W'(1);
                default: inflight <= inflight;
            endcase

            // Placed after the start-of-sweep clear so an unexpected result
            // in the same cycle as i_start is still flagged.
            if (stray) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule
